// File: rtl/layer_serializer.sv
// layer_serializer: collects one layer's parallel neuron results into a capture
// buffer and streams them out one word per cycle, neuron 0 first. The capture
// buffer and the shifter form a double buffer, so the next result set can be
// collected while the current burst is streaming.
// Optional feature: define LAYER_SER_ARGMAX_EN to add the max_idx/max_valid
// ports and a running signed argmax over each emitted burst.
module layer_serializer #(
  parameter int unsigned NEURON_NUM = 30,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = $clog2(NEURON_NUM)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NEURON_NUM*DATA_WIDTH-1:0] in_data,
  input  logic [NEURON_NUM-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic [IDX_WIDTH-1:0]             out_idx,
  output logic                             busy,
  output logic                             overflow
`ifdef LAYER_SER_ARGMAX_EN
  ,
  output logic [IDX_WIDTH-1:0]             max_idx,
  output logic                             max_valid
`endif
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NEURON_NUM - 1);

  typedef logic [NEURON_NUM-1:0][DATA_WIDTH-1:0] word_arr_t;
  typedef enum logic [0:0] {StIdle, StShift} state_e;

  word_arr_t                in_words;
  word_arr_t                cap_q, cap_d;
  word_arr_t                shift_q, shift_d;
  logic [NEURON_NUM-1:0]    mask_q, mask_d, mask_base;
  logic [IDX_WIDTH-1:0]     cnt_q, cnt_d, cnt_nxt;
  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [IDX_WIDTH-1:0]     out_idx_q, out_idx_d;
  logic                     busy_q, busy_d;
  logic                     overflow_q, overflow_d;
  logic                     full;

  // Word i of the packed input bus lands in element i.
  assign in_words = in_data;
  assign full     = &mask_q;
  assign cnt_nxt  = cnt_q + IDX_WIDTH'(1);

  // Next-state logic: FSM, shifter/counter, output words and capture stage.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_idx_d   = out_idx_q;
    mask_base   = mask_q;

    unique case (state_q)
      StIdle: begin
        if (full) begin
          state_d     = StShift;
          shift_d     = cap_q;
          cnt_d       = '0;
          out_data_d  = cap_q[0];
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          mask_base   = '0;
        end
      end
      StShift: begin
        if (cnt_q != LastIdx) begin
          cnt_d       = cnt_nxt;
          out_data_d  = shift_q[cnt_nxt];
          out_valid_d = 1'b1;
          out_idx_d   = cnt_nxt;
          out_last_d  = (cnt_nxt == LastIdx);
        end else if (full) begin
          // Back-to-back reload: word 0 of the next set follows the last word directly.
          shift_d     = cap_q;
          cnt_d       = '0;
          out_data_d  = cap_q[0];
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          mask_base   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture decisions use the post-transfer mask so a word arriving on the
    // transfer edge starts the next set instead of being flagged as overflow.
    mask_d     = mask_base;
    cap_d      = cap_q;
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < NEURON_NUM; i++) begin
      if (in_valid[i]) begin
        if (mask_base[i]) begin
          overflow_d = 1'b1;
        end else begin
          cap_d[i]  = in_words[i];
          mask_d[i] = 1'b1;
        end
      end
    end

    busy_d = (state_d == StShift) | (|mask_d);
  end

  // State and output registers; reset aborts any burst and drops a partial set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      cap_q       <= '0;
      mask_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      cap_q       <= cap_d;
      mask_q      <= mask_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

`ifdef LAYER_SER_ARGMAX_EN
  logic signed [DATA_WIDTH-1:0] run_val_q, run_val_d;
  logic [IDX_WIDTH-1:0]         run_idx_q, run_idx_d;
  logic [IDX_WIDTH-1:0]         max_idx_q, max_idx_d;
  logic                         max_valid_q, max_valid_d;

  // Running argmax over the registered stream; strict > keeps the lower index on ties.
  always_comb begin
    run_val_d   = run_val_q;
    run_idx_d   = run_idx_q;
    max_idx_d   = max_idx_q;
    max_valid_d = 1'b0;
    if (out_valid_q) begin
      if ((out_idx_q == '0) || ($signed(out_data_q) > run_val_q)) begin
        run_val_d = out_data_q;
        run_idx_d = out_idx_q;
      end
      if (out_last_q) begin
        max_idx_d   = run_idx_d;
        max_valid_d = 1'b1;
      end
    end
  end

  // Argmax registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_val_q   <= '0;
      run_idx_q   <= '0;
      max_idx_q   <= '0;
      max_valid_q <= 1'b0;
    end else begin
      run_val_q   <= run_val_d;
      run_idx_q   <= run_idx_d;
      max_idx_q   <= max_idx_d;
      max_valid_q <= max_valid_d;
    end
  end

  assign max_idx   = max_idx_q;
  assign max_valid = max_valid_q;
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer (NEURON_NUM=10). Expected words are
// pushed to a scoreboard when a set is driven and popped as the stream appears.
module tb_layer_serializer;

  localparam int unsigned N  = 10;
  localparam int unsigned W  = 16;
  localparam int unsigned IW = $clog2(N);

  typedef logic [N-1:0][W-1:0] set_t;
  typedef struct packed {
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic [IW-1:0]  out_idx;
  logic           busy;
  logic           overflow;
`ifdef LAYER_SER_ARGMAX_EN
  logic [IW-1:0]  max_idx;
  logic           max_valid;
`endif

  exp_t          exp_q[$];
  logic [IW-1:0] max_q[$];
  int            checks = 0;
  int            errors = 0;
  int            run_len = 0;
  int            max_run = 0;
  logic          run_clr = 1'b0;

  layer_serializer #(
    .NEURON_NUM(N),
    .DATA_WIDTH(W),
    .IDX_WIDTH (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_idx  (out_idx),
    .busy     (busy),
    .overflow (overflow)
`ifdef LAYER_SER_ARGMAX_EN
    ,
    .max_idx  (max_idx),
    .max_valid(max_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic set_t ramp(input logic [W-1:0] base);
    set_t s;
    for (int i = 0; i < N; i++) s[i] = base + W'(i);
    return s;
  endfunction

  // Queue the expected stream and the expected argmax (first strict maximum).
  task automatic push_set(input set_t s);
    exp_t                 e;
    logic [IW-1:0]        bi;
    logic signed [W-1:0]  bv;
    bi = '0;
    bv = s[0];
    for (int i = 0; i < N; i++) begin
      e.data = s[i];
      e.idx  = IW'(i);
      e.last = (i == N - 1);
      exp_q.push_back(e);
      if ($signed(s[i]) > bv) begin
        bv = s[i];
        bi = IW'(i);
      end
    end
    max_q.push_back(bi);
  endtask

  // Called at posedge+1; drives one in_valid pulse sampled on the next edge.
  task automatic pulse(input logic [N-1:0] v, input set_t d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 200);
    check(tag, 32'(busy || exp_q.size() != 0), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    logic prev_last;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (run_clr) max_run = 0;
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_idx", 32'(out_idx), 32'(e.idx));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end else begin
        run_len = 0;
      end
`ifdef LAYER_SER_ARGMAX_EN
      check("max_valid_timing", 32'(max_valid), 32'(prev_last));
      if (max_valid) begin
        if (max_q.size() == 0) check("max_unexpected", 32'(max_q.size()), 32'd1);
        else check("max_idx", 32'(max_idx), 32'(max_q.pop_front()));
      end
      prev_last = out_valid & out_last;
`endif
    end
  endtask

  initial begin
    set_t         s, s2;
    logic [N-1:0] v;
    logic         found;
    in_valid = '0;
    in_data  = '0;
    rst      = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
`ifdef LAYER_SER_ARGMAX_EN
    check("rst_max_valid", 32'(max_valid), 32'd0);
    check("rst_max_idx", 32'(max_idx), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: full set in one cycle, one-cycle latency.
    s = ramp(16'h0100);
    push_set(s);
    pulse('1, s);
    @(negedge clk);
    check("t1_latency0", 32'(out_valid), 32'd0);
    check("t1_busy_capture", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_latency1", 32'(out_valid), 32'd1);
    wait_idle("t1_idle");

    // 2: staggered bits in reverse order.
    s = ramp(16'h0300);
    push_set(s);
    for (int i = N - 1; i >= 0; i--) begin
      v    = '0;
      v[i] = 1'b1;
      pulse(v, s);
      if (i > 0) begin
        check("t2_no_output", 32'(out_valid), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
      end
    end
    @(negedge clk);
    check("t2_latency0", 32'(out_valid), 32'd0);
    wait_idle("t2_idle");

    // 3: second set completes mid-burst; bursts must be gapless.
    run_clr = 1'b1;
    @(posedge clk);
    #1;
    run_clr = 1'b0;
    s = ramp(16'h0500);
    push_set(s);
    pulse('1, s);
    repeat (3) @(posedge clk);
    #1;
    s2 = ramp(16'h0600);
    push_set(s2);
    pulse('1, s2);
    wait_idle("t3_idle");
    check("t3_gapless_run", 32'(max_run), 32'd20);
    check("t3_overflow", 32'(overflow), 32'd0);

    // 4: duplicate word 3 is dropped and overflow is sticky.
    s    = ramp(16'h0700);
    s[3] = 16'h1111;
    push_set(s);
    v    = '0;
    v[3] = 1'b1;
    pulse(v, s);
    check("t4_overflow_clear", 32'(overflow), 32'd0);
    s2    = s;
    s2[3] = 16'h2222;
    pulse(v, s2);
    check("t4_overflow_set", 32'(overflow), 32'd1);
    pulse(~v, s2);
    wait_idle("t4_idle");
    check("t4_overflow_sticky", 32'(overflow), 32'd1);

    // 5: asynchronous reset at word 5 aborts the burst.
    s = ramp(16'h0900);
    push_set(s);
    pulse('1, s);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (out_valid && out_idx == IW'(5)) found = 1'b1;
    end
    check("t5_reached_word5", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_data", 32'(out_data), 32'd0);
    check("t5_async_idx", 32'(out_idx), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    max_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("t5_no_words", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    s = ramp(16'h0A00);
    push_set(s);
    pulse('1, s);
    wait_idle("t5_resume_idle");

`ifdef LAYER_SER_ARGMAX_EN
    // 6: argmax with a tie, then an all-negative ascending set.
    s    = '0;
    s[0] = 16'h0005;
    s[1] = 16'hFFFD;
    s[2] = 16'h0009;
    s[3] = 16'h0009;
    push_set(s);
    pulse('1, s);
    wait_idle("t6a_idle");
    for (int i = 0; i < N; i++) s[i] = W'(i - 10);
    push_set(s);
    pulse('1, s);
    wait_idle("t6b_idle");
    @(negedge clk);
    check("t6_all_pulses_seen", 32'(max_q.size()), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
